// File: rtl/bus_arbiter_rr_if.sv
// Request/grant bundle between the shared-bus masters and the round-robin arbiter.
// Handshake: bus_req[i] is a level held for the whole transaction; bus_ack[i] (registered,
// one-hot or zero) grants ownership; dropping bus_req ends the grant at the next edge.
interface bus_arbiter_rr_if #(
  parameter int NREQ = 8,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
);
  logic [NREQ-1:0] bus_req;
  logic            bus_ready;
  logic [NREQ-1:0] bus_ack;
  logic [IDW-1:0]  bus_owner;
  logic            bus_busy;

  // Requester side
  modport master (
    output bus_req,
    output bus_ready,
    input  bus_ack,
    input  bus_owner,
    input  bus_busy
  );

  // Arbiter side
  modport slave (
    input  bus_req,
    input  bus_ready,
    output bus_ack,
    output bus_owner,
    output bus_busy
  );
endinterface

// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter with whole-transaction grants and a one-cycle turnaround.
// Optional per-grant beat limit enabled by defining BUSARB_HOLD_LIMIT_EN.
module bus_arbiter_rr #(
  parameter int NREQ     = 8,
  parameter int IDW      = (NREQ > 1) ? $clog2(NREQ) : 1,
  parameter int HOLD_MAX = 16
) (
  input  logic           clk,
  input  logic           Nrst,
  bus_arbiter_rr_if.slave bus,
  output logic [1:0]     dbg_state,
  output logic [IDW-1:0] dbg_rr_ptr
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_t;

  if (NREQ < 1 || NREQ > 32) begin : g_bad_nreq
    $error("bus_arbiter_rr: NREQ out of range");
  end
  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold
    $error("bus_arbiter_rr: HOLD_MAX out of range");
  end

  state_t          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [IDW-1:0]  owner_q, owner_d;
  logic            busy_q, busy_d;

  logic            found;
  logic [IDW-1:0]  winner;
  logic [IDW-1:0]  winner_nxt;
  logic            owner_req;
  logic            revoke;

  // Search from rr_ptr upward, wrapping modulo NREQ (not modulo 2^IDW).
  always_comb begin
    int idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && bus.bus_req[idx]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
    winner_nxt = (int'(winner) == NREQ - 1) ? '0 : winner + 1'b1;
  end

  assign owner_req = bus.bus_req[owner_q];

`ifdef BUSARB_HOLD_LIMIT_EN
  logic [7:0] cnt_q, cnt_d;
  logic [8:0] cnt_inc;
  logic       cnt_hit;
  logic       others_req;

  assign cnt_inc    = {1'b0, cnt_q} + 9'd1;
  assign cnt_hit    = (cnt_inc >= 9'(HOLD_MAX));
  assign others_req = |(bus.bus_req & ~ack_q);
  assign revoke     = (state_q == ST_GRANT) && bus.bus_ready && others_req && cnt_hit;
`else
  assign revoke = 1'b0;
`endif

  // State register: FSM state and every registered output.
  always_ff @(posedge clk or negedge Nrst) begin
    if (!Nrst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      ack_q    <= '0;
      owner_q  <= '0;
      busy_q   <= 1'b0;
`ifdef BUSARB_HOLD_LIMIT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      ack_q    <= ack_d;
      owner_q  <= owner_d;
      busy_q   <= busy_d;
`ifdef BUSARB_HOLD_LIMIT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (found) state_d = ST_GRANT;
      ST_GRANT: if (!owner_req || revoke) state_d = ST_TURN;
      ST_TURN:  state_d = found ? ST_GRANT : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output logic: next values of the registered grant, owner, pointer and beat count.
  always_comb begin
    ack_d    = ack_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
`ifdef BUSARB_HOLD_LIMIT_EN
    cnt_d    = cnt_q;
`endif
    if (state_q != ST_GRANT && found) begin
      ack_d         = '0;
      ack_d[winner] = 1'b1;
      owner_d       = winner;
      rr_ptr_d      = winner_nxt;
`ifdef BUSARB_HOLD_LIMIT_EN
      cnt_d         = '0;
`endif
    end else if (state_q == ST_GRANT && state_d == ST_TURN) begin
      ack_d = '0;
    end else if (state_q != ST_GRANT) begin
      ack_d = '0;
    end
`ifdef BUSARB_HOLD_LIMIT_EN
    else if (bus.bus_ready && cnt_q != 8'(HOLD_MAX)) begin
      // Saturates at HOLD_MAX so a lone owner keeps the bus without wrapping.
      cnt_d = cnt_hit ? 8'(HOLD_MAX) : cnt_inc[7:0];
    end
`endif
    busy_d = |ack_d;
  end

  assign bus.bus_ack   = ack_q;
  assign bus.bus_owner = owner_q;
  assign bus.bus_busy  = busy_q;
  assign dbg_state     = state_q;
  assign dbg_rr_ptr    = rr_ptr_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr (NREQ=8, HOLD_MAX=4); hold-limit expectations
// follow BUSARB_HOLD_LIMIT_EN.
module tb_bus_arbiter_rr;

  localparam int NREQ = 8;
  localparam int IDW  = 3;

  logic           clk;
  logic           Nrst;
  logic [1:0]     dbg_state;
  logic [IDW-1:0] dbg_rr_ptr;

  int n_vec = 0;
  int n_err = 0;

  bus_arbiter_rr_if #(.NREQ(NREQ), .IDW(IDW)) bus_if ();

  bus_arbiter_rr #(.NREQ(NREQ), .IDW(IDW), .HOLD_MAX(4)) dut (
    .clk       (clk),
    .Nrst      (Nrst),
    .bus       (bus_if),
    .dbg_state (dbg_state),
    .dbg_rr_ptr(dbg_rr_ptr)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply inputs, advance one edge, then check grant, busy and (when granted) owner.
  task automatic cyc(input logic [7:0] req, input logic rdy, input logic [7:0] exp_ack,
                     input int exp_owner, input string tag);
    bus_if.bus_req   = req;
    bus_if.bus_ready = rdy;
    @(posedge clk);
    #1;
    chk({tag, ".ack"}, 32'(bus_if.bus_ack), 32'(exp_ack));
    chk({tag, ".busy"}, 32'(bus_if.bus_busy), 32'(exp_ack != 8'h00));
    if (exp_ack != 8'h00) chk({tag, ".owner"}, 32'(bus_if.bus_owner), 32'(exp_owner));
  endtask

  task automatic do_reset();
    bus_if.bus_req   = '0;
    bus_if.bus_ready = 1'b0;
    Nrst = 1'b0;
    @(posedge clk);
    #1;
    Nrst = 1'b1;
  endtask

  initial begin
    bus_if.bus_req   = 8'hFF;
    bus_if.bus_ready = 1'b0;
    Nrst = 1'b0;

    // Reset holds everything idle even with all channels requesting
    repeat (3) @(posedge clk);
    #1;
    chk("rst.ack", 32'(bus_if.bus_ack), 32'h00);
    chk("rst.busy", 32'(bus_if.bus_busy), 32'h0);
    chk("rst.owner", 32'(bus_if.bus_owner), 32'h0);
    chk("rst.state", 32'(dbg_state), 32'h0);
    chk("rst.ptr", 32'(dbg_rr_ptr), 32'h0);
    Nrst = 1'b1;
    cyc(8'h02, 1'b0, 8'h02, 1, "first");
    chk("first.ptr", 32'(dbg_rr_ptr), 32'h2);
    cyc(8'h03, 1'b0, 8'h02, 1, "ignore_other");

    // Rotation: ch0, ch1, ch7, ch0 with one dead cycle per handover
    do_reset();
    cyc(8'h83, 1'b0, 8'h01, 0, "rot0a");
    cyc(8'h83, 1'b0, 8'h01, 0, "rot0b");
    cyc(8'h83, 1'b0, 8'h01, 0, "rot0c");
    cyc(8'h82, 1'b0, 8'h00, 0, "rot0_turn");
    chk("rot0_turn.state", 32'(dbg_state), 32'h2);
    cyc(8'h83, 1'b0, 8'h02, 1, "rot1a");
    cyc(8'h83, 1'b0, 8'h02, 1, "rot1b");
    cyc(8'h83, 1'b0, 8'h02, 1, "rot1c");
    cyc(8'h81, 1'b0, 8'h00, 0, "rot1_turn");
    cyc(8'h83, 1'b0, 8'h80, 7, "rot7a");
    cyc(8'h83, 1'b0, 8'h80, 7, "rot7b");
    cyc(8'h83, 1'b0, 8'h80, 7, "rot7c");
    cyc(8'h03, 1'b0, 8'h00, 0, "rot7_turn");
    cyc(8'h83, 1'b0, 8'h01, 0, "rot0_again");

    // Turnaround and pointer wrap
    do_reset();
    cyc(8'h80, 1'b0, 8'h80, 7, "wrap7");
    chk("wrap7.ptr", 32'(dbg_rr_ptr), 32'h0);
    cyc(8'h01, 1'b0, 8'h00, 0, "wrap_turn");
    cyc(8'h01, 1'b0, 8'h01, 0, "wrap0");
    chk("wrap0.ptr", 32'(dbg_rr_ptr), 32'h1);
    cyc(8'h00, 1'b0, 8'h00, 0, "wrap_rel");
    cyc(8'h00, 1'b0, 8'h00, 0, "wrap_idle");
    chk("wrap_idle.state", 32'(dbg_state), 32'h0);

    // Asynchronous reset mid-grant
    do_reset();
    cyc(8'h08, 1'b0, 8'h08, 3, "mid3");
    #2;
    Nrst = 1'b0;
    #1;
    chk("midrst.ack", 32'(bus_if.bus_ack), 32'h00);
    chk("midrst.busy", 32'(bus_if.bus_busy), 32'h0);
    chk("midrst.ptr", 32'(dbg_rr_ptr), 32'h0);
    #1;
    Nrst = 1'b1;
    cyc(8'h18, 1'b0, 8'h08, 3, "after_rst");

    // Beat limit: ch0 and ch2 requesting, four ready pulses on ch0
    do_reset();
    cyc(8'h05, 1'b0, 8'h01, 0, "hold_g");
    cyc(8'h05, 1'b1, 8'h01, 0, "hold_p1");
    cyc(8'h05, 1'b1, 8'h01, 0, "hold_p2");
    cyc(8'h05, 1'b1, 8'h01, 0, "hold_p3");
`ifdef BUSARB_HOLD_LIMIT_EN
    cyc(8'h05, 1'b1, 8'h00, 0, "hold_p4");
    cyc(8'h05, 1'b0, 8'h04, 2, "hold_next");
`else
    cyc(8'h05, 1'b1, 8'h01, 0, "hold_p4");
    cyc(8'h05, 1'b1, 8'h01, 0, "hold_p5");
    cyc(8'h05, 1'b0, 8'h01, 0, "hold_keep");
`endif

    // Lone requester saturates the counter, then a competitor arrives
    do_reset();
    cyc(8'h20, 1'b0, 8'h20, 5, "solo_g");
    for (int i = 0; i < 10; i++) cyc(8'h20, 1'b1, 8'h20, 5, "solo_p");
    cyc(8'h22, 1'b0, 8'h20, 5, "solo_comp");
`ifdef BUSARB_HOLD_LIMIT_EN
    cyc(8'h22, 1'b1, 8'h00, 0, "solo_revoke");
    cyc(8'h22, 1'b0, 8'h02, 1, "solo_next");
`else
    cyc(8'h22, 1'b1, 8'h20, 5, "solo_keep");
    cyc(8'h22, 1'b0, 8'h20, 5, "solo_keep2");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
